vc_outport: RTL and testbench

VC_OUTPORT -- requirements
Module: vc_outport

---
 rtl/vc_outport.sv | 214 +++++++++++++++++++++
 tb/tb_vc_outport.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_outport.sv
// vc_outport: virtual-channel output port.
//
// PN input ports compete for one output link that carries VCN virtual
// channels. Each VC has a credit counter that tracks free slots in the
// downstream buffer. A packet's head flit claims a free VC. Its body and tail
// flits follow on that VC. The tail flit releases the VC.
//
// Only one flit is granted per cycle. The grant rotates round-robin among the
// eligible ports. A granted flit is registered and appears on the out_* port
// in the next cycle.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   in_vld        per-port flit request                  [PN]
//   in_data       per-port payload, port p at [p*DW +: DW]
//   in_ft         per-port flit type {TAIL, DATA, HD}, port p at [p*FT +: FT]
//   in_gnt        one-hot grant; the flit is consumed in the grant cycle [PN]
//   out_vld       one-cycle flit-valid pulse
//   out_data/out_ft/out_vc  registered flit and one-hot VC (held when idle)
//   credit        per-VC credit-return pulse from downstream [VCN]
//   err           sticky protocol / credit-overflow flag
//   stat_flits    sent-flit counter, only when VC_OUTPORT_STATS_EN is defined
//
// Optional feature: define VC_OUTPORT_STATS_EN to build the 16-bit flit counter.
// Without the macro, stat_flits is tied to zero.

module vc_outport #(
  parameter int VCN  = 2,
  parameter int DW   = 32,
  parameter int FT   = 3,
  parameter int FCPD = 1,
  parameter int PN   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PN-1:0]     in_vld,
  input  logic [PN*DW-1:0]  in_data,
  input  logic [PN*FT-1:0]  in_ft,
  output logic [PN-1:0]     in_gnt,
  output logic              out_vld,
  output logic [DW-1:0]     out_data,
  output logic [FT-1:0]     out_ft,
  output logic [VCN-1:0]    out_vc,
  input  logic [VCN-1:0]    credit,
  output logic              err,
  output logic [15:0]       stat_flits
);

  localparam int PW = (PN > 1) ? $clog2(PN) : 1;
  localparam int VW = (VCN > 1) ? $clog2(VCN) : 1;
  localparam logic [3:0] CMAX = 4'(FCPD);

  typedef enum logic {VC_FREE, VC_BUSY} vc_state_t;
  typedef enum logic {P_IDLE, P_HOLD} port_state_t;

  // The VC-to-owner mapping is stored on the port side (p_vc).
  // A busy VC therefore needs only its state bit here.
  vc_state_t   vc_st [VCN];
  logic [3:0]  cnt   [VCN];
  port_state_t p_st  [PN];
  logic [VW-1:0] p_vc [PN];
  logic [PW-1:0] rr_ptr;

  logic [DW-1:0] data_a [PN];
  logic [FT-1:0] ft_a   [PN];
  logic [PN-1:0] hd, tl;

  // Split the flat input buses into per-port fields.
  for (genvar g = 0; g < PN; g++) begin : g_split
    assign data_a[g] = in_data[g*DW +: DW];
    assign ft_a[g]   = in_ft[g*FT +: FT];
    assign hd[g]     = in_ft[g*FT];
    assign tl[g]     = in_ft[g*FT + 2];
  end

  // Find the VCs that can accept a new head flit.
  // The loop runs downward so that the lowest-index candidate is written last
  // and therefore wins.
  logic [VCN-1:0] vc_avail;
  logic           any_avail;
  logic [VW-1:0]  alloc_vc;
  always_comb begin
    vc_avail = '0;
    alloc_vc = '0;
    for (int v = VCN - 1; v >= 0; v--) begin
      if (vc_st[v] == VC_FREE && cnt[v] != 4'd0) begin
        vc_avail[v] = 1'b1;
        alloc_vc    = VW'(v);
      end
    end
    any_avail = |vc_avail;
  end

  // Classify each request as eligible, waiting, or a protocol violation.
  // A violation never produces a grant.
  // Eligibility uses the registered credit count, so a credit that arrives
  // this cycle cannot unblock a grant in the same cycle.
  logic [PN-1:0] elig, proto_err;
  always_comb begin
    elig      = '0;
    proto_err = '0;
    for (int p = 0; p < PN; p++) begin
      if (in_vld[p]) begin
        if (p_st[p] == P_HOLD) begin
          if (hd[p])                       proto_err[p] = 1'b1;
          else if (cnt[p_vc[p]] != 4'd0)   elig[p]      = 1'b1;
        end else begin
          if (!hd[p])                      proto_err[p] = 1'b1;
          else if (any_avail)              elig[p]      = 1'b1;
        end
      end
    end
  end

  // Round-robin search.
  // It starts one past the last granted port and wraps modulo PN.
  logic          gnt_any;
  logic [PW-1:0] gnt_p;
  logic [PW-1:0] idx;
  always_comb begin
    gnt_any = 1'b0;
    gnt_p   = '0;
    idx     = '0;
    for (int k = 1; k <= PN; k++) begin
      idx = PW'((int'(rr_ptr) + k) % PN);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_p   = idx;
      end
    end
  end

  // A held port keeps its VC. An idle port takes the lowest available VC.
  logic [VW-1:0] gnt_vc;
  assign gnt_vc = (p_st[gnt_p] == P_HOLD) ? p_vc[gnt_p] : alloc_vc;
  assign in_gnt = (gnt_any && !rst) ? (PN'(1) << gnt_p) : '0;

  // Per-VC credit bookkeeping.
  // A send and a credit return in the same cycle cancel out.
  // A credit that arrives at a VC already holding FCPD credits is dropped and
  // flagged as an error.
  logic [VCN-1:0] vc_dec, vc_inc, vc_ovf;
  always_comb begin
    vc_dec = '0;
    vc_inc = '0;
    vc_ovf = '0;
    for (int v = 0; v < VCN; v++) begin
      vc_dec[v] = gnt_any && (gnt_vc == VW'(v));
      vc_ovf[v] = credit[v] && (cnt[v] == CMAX);
      vc_inc[v] = credit[v] && (cnt[v] != CMAX);
    end
  end

  // Main state register: credits, ownership, round-robin pointer, output stage.
  // A reset in the middle of a packet drops all ownership, so the next head flit
  // starts from a clean allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VCN; v++) begin
        cnt[v]   <= CMAX;
        vc_st[v] <= VC_FREE;
      end
      for (int p = 0; p < PN; p++) begin
        p_st[p] <= P_IDLE;
        p_vc[p] <= '0;
      end
      rr_ptr   <= PW'(PN - 1);
      err      <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ft   <= '0;
      out_vc   <= '0;
    end else begin
      err <= err | (|proto_err) | (|vc_ovf);
      for (int v = 0; v < VCN; v++) begin
        case ({vc_dec[v], vc_inc[v]})
          2'b10:   cnt[v] <= cnt[v] - 4'd1;
          2'b01:   cnt[v] <= cnt[v] + 4'd1;
          default: cnt[v] <= cnt[v];
        endcase
      end
      out_vld <= gnt_any;
      if (gnt_any) begin
        out_data <= data_a[gnt_p];
        out_ft   <= ft_a[gnt_p];
        out_vc   <= VCN'(1) << gnt_vc;
        rr_ptr   <= gnt_p;
        if (tl[gnt_p]) begin
          vc_st[gnt_vc] <= VC_FREE;
          p_st[gnt_p]   <= P_IDLE;
        end else begin
          vc_st[gnt_vc] <= VC_BUSY;
          p_st[gnt_p]   <= P_HOLD;
          p_vc[gnt_p]   <= gnt_vc;
        end
      end
    end
  end

`ifdef VC_OUTPORT_STATS_EN
  // The counter advances on the same edge that raises out_vld.
  // It therefore always equals the number of out_vld pulses issued so far,
  // and it wraps naturally at 16 bits.
  logic [15:0] flit_cnt;
  always_ff @(posedge clk) begin
    if (rst)          flit_cnt <= '0;
    else if (gnt_any) flit_cnt <= flit_cnt + 16'd1;
  end
  assign stat_flits = flit_cnt;
`else
  assign stat_flits = 16'h0;
`endif

endmodule

// File: tb/tb_vc_outport.sv
// tb_vc_outport: testbench for vc_outport.
//
// A reference model tracks credits, VC ownership, port packet state and the
// round-robin pointer using plain integers.
// On every falling edge the model:
//   - predicts in_gnt for the current inputs;
//   - compares in_gnt and all registered outputs against the DUT;
//   - advances its own state for the next rising edge.
//
// Directed stimulus walks through packet flow, round-robin order, VC exhaustion,
// credit stall, credit overflow, mid-packet reset and the stats counter.
// Hand-computed literal checks along the way pin the model itself.

module tb_vc_outport;

  localparam int VCN  = 2;
  localparam int DW   = 32;
  localparam int FT   = 3;
  localparam int FCPD = 4;
  localparam int PN   = 5;

  localparam logic [FT-1:0] HD = 3'b001;
  localparam logic [FT-1:0] DT = 3'b010;
  localparam logic [FT-1:0] TL = 3'b100;
  localparam logic [FT-1:0] HT = 3'b101;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PN-1:0]    in_vld = '0;
  logic [PN*DW-1:0] in_data = '0;
  logic [PN*FT-1:0] in_ft = '0;
  logic [PN-1:0]    in_gnt;
  logic             out_vld;
  logic [DW-1:0]    out_data;
  logic [FT-1:0]    out_ft;
  logic [VCN-1:0]   out_vc;
  logic [VCN-1:0]   credit = '0;
  logic             err;
  logic [15:0]      stat_flits;

  int checks = 0;
  int errors = 0;
  logic [PN-1:0] sampledGnt;

  always #5 clk = ~clk;

  vc_outport #(.VCN(VCN), .DW(DW), .FT(FT), .FCPD(FCPD), .PN(PN)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_ft(in_ft),
    .in_gnt(in_gnt), .out_vld(out_vld), .out_data(out_data), .out_ft(out_ft),
    .out_vc(out_vc), .credit(credit), .err(err), .stat_flits(stat_flits)
  );

  // Single comparison point shared by the model and the literal checks.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  // Ownership is stored as integers, with -1 meaning free/idle.
  int          mCred   [VCN];
  int          mOwner  [VCN];
  int          mPortVc [PN];
  int          mLast;
  logic        mErr;
  logic        mVld;
  logic [DW-1:0]  mData;
  logic [FT-1:0]  mFt;
  logic [VCN-1:0] mVc;
  logic [15:0] mFlits;
  bit          modelValid = 0;

  function automatic bit portEligible(input int p);
    bit h;
    h = in_ft[p*FT];
    if (!in_vld[p]) return 0;
    if (mPortVc[p] >= 0) return !h && (mCred[mPortVc[p]] > 0);
    if (!h) return 0;
    for (int v = 0; v < VCN; v++)
      if (mOwner[v] < 0 && mCred[v] > 0) return 1;
    return 0;
  endfunction

  // Each falling edge: predict, compare, then advance the model.
  always @(negedge clk) begin
    int g;
    int v;
    int oldCred [VCN];
    logic [PN-1:0] expGnt;
    logic [15:0] expStat;
    g = -1;
    expGnt = '0;
    if (modelValid && !rst) begin
      for (int k = 1; k <= PN; k++) begin
        int p;
        p = (mLast + k) % PN;
        if (g < 0 && portEligible(p)) g = p;
      end
    end
    if (g >= 0) expGnt[g] = 1'b1;
    if (modelValid) begin
`ifdef VC_OUTPORT_STATS_EN
      expStat = mFlits;
`else
      expStat = 16'h0;
`endif
      checkOutput("model_in_gnt", in_gnt, expGnt);
      checkOutput("model_out_vld", out_vld, mVld);
      checkOutput("model_out_data", out_data, mData);
      checkOutput("model_out_ft", out_ft, mFt);
      checkOutput("model_out_vc", out_vc, mVc);
      checkOutput("model_err", err, mErr);
      checkOutput("model_stat_flits", stat_flits, expStat);
    end
    if (rst) begin
      for (int u = 0; u < VCN; u++) begin
        mCred[u] = FCPD;
        mOwner[u] = -1;
      end
      for (int p = 0; p < PN; p++) mPortVc[p] = -1;
      mLast = PN - 1;
      mErr = 0; mVld = 0; mData = '0; mFt = '0; mVc = '0; mFlits = '0;
      modelValid = 1;
    end else if (modelValid) begin
      for (int u = 0; u < VCN; u++) oldCred[u] = mCred[u];
      for (int p = 0; p < PN; p++)
        if (in_vld[p] && ((mPortVc[p] < 0 && !in_ft[p*FT]) || (mPortVc[p] >= 0 && in_ft[p*FT])))
          mErr = 1;
      for (int u = 0; u < VCN; u++)
        if (credit[u]) begin
          if (oldCred[u] == FCPD) mErr = 1;
          else mCred[u] = mCred[u] + 1;
        end
      if (g >= 0) begin
        v = mPortVc[g];
        if (v < 0) begin
          for (int u = VCN - 1; u >= 0; u--)
            if (mOwner[u] < 0 && oldCred[u] > 0) v = u;
        end
        mCred[v] = mCred[v] - 1;
        mVld = 1;
        mData = in_data[g*DW +: DW];
        mFt = in_ft[g*FT +: FT];
        mVc = '0;
        mVc[v] = 1'b1;
        mFlits = mFlits + 16'd1;
        mLast = g;
        if (in_ft[g*FT + 2]) begin
          mOwner[v] = -1;
          mPortVc[g] = -1;
        end else begin
          mOwner[v] = g;
          mPortVc[g] = v;
        end
      end else begin
        mVld = 0;
      end
    end
  end

  task automatic setPort(input int p, input logic [FT-1:0] ft, input logic [DW-1:0] d);
    in_vld[p] = 1'b1;
    in_ft[p*FT +: FT] = ft;
    in_data[p*DW +: DW] = d;
  endtask

  // One cycle: apply credits, sample the combinational grant, cross the edge,
  // then withdraw all requests.
  task automatic applyStimulus(input logic [VCN-1:0] cred);
    credit = cred;
    #2;
    sampledGnt = in_gnt;
    @(posedge clk);
    #1;
    in_vld = '0;
    credit = '0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Initial reset. A request is held during reset to show that no grant is issued.
    setPort(0, HD, 32'hDEAD0000);
    applyStimulus('0);
    checkOutput("gnt_during_reset", sampledGnt, 5'b00000);
    applyStimulus('0);
    applyStimulus('0);
    rst = 1'b0;
    checkOutput("reset_out_vld", out_vld, 1'b0);
    checkOutput("reset_out_vc", out_vc, 2'b00);
    checkOutput("reset_out_data", out_data, 32'h0);
    checkOutput("reset_out_ft", out_ft, 3'b000);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_stat", stat_flits, 16'h0);

    // Port 0 sends a head, body, tail packet on VC0.
    setPort(0, HD, 32'h100); applyStimulus('0);
    checkOutput("p0_head_gnt", sampledGnt, 5'b00001);
    checkOutput("p0_head_vld", out_vld, 1'b1);
    checkOutput("p0_head_vc", out_vc, 2'b01);
    checkOutput("p0_head_data", out_data, 32'h100);
    setPort(0, DT, 32'h101); applyStimulus('0);
    checkOutput("p0_body_gnt", sampledGnt, 5'b00001);
    checkOutput("p0_body_vc", out_vc, 2'b01);
    checkOutput("p0_body_ft", out_ft, DT);
    setPort(0, TL, 32'h102); applyStimulus('0);
    checkOutput("p0_tail_vc", out_vc, 2'b01);
    // VC0 is free again with one credit left, so a single-flit packet reuses it.
    setPort(0, HT, 32'h103); applyStimulus('0);
    checkOutput("p0_single_vc", out_vc, 2'b01);
    // VC0 now has no credits, so the next head moves to VC1.
    setPort(0, HD, 32'h104); applyStimulus('0);
    checkOutput("p0_head_vc1", out_vc, 2'b10);
    setPort(0, TL, 32'h105); applyStimulus('0);
    checkOutput("p0_tail_vc1_gnt", sampledGnt, 5'b00001);
    // Return all credits. Outputs must hold their last value while idle.
    applyStimulus(2'b11);
    checkOutput("idle_out_vld", out_vld, 1'b0);
    checkOutput("idle_out_data_hold", out_data, 32'h105);
    applyStimulus(2'b01);
    applyStimulus(2'b01);
    applyStimulus(2'b11);
    checkOutput("credits_back_err", err, 1'b0);

    // Move the round-robin pointer to port 4, then present heads from ports 1 and 3.
    setPort(4, HT, 32'h400); applyStimulus('0);
    checkOutput("p4_gnt", sampledGnt, 5'b10000);
    setPort(1, HD, 32'h110); setPort(3, HD, 32'h130); applyStimulus(2'b01);
    checkOutput("rr_p1_gnt", sampledGnt, 5'b00010);
    checkOutput("rr_p1_vc", out_vc, 2'b01);
    setPort(3, HD, 32'h130); applyStimulus('0);
    checkOutput("rr_p3_gnt", sampledGnt, 5'b01000);
    checkOutput("rr_p3_vc", out_vc, 2'b10);

    // Both VCs are busy, so port 2's head waits until port 1's tail frees VC0.
    setPort(2, HD, 32'h120); applyStimulus('0);
    checkOutput("busy_wait_gnt", sampledGnt, 5'b00000);
    setPort(2, HD, 32'h120); applyStimulus('0);
    checkOutput("busy_wait_vld", out_vld, 1'b0);
    setPort(2, HD, 32'h120); setPort(1, TL, 32'h111); applyStimulus('0);
    checkOutput("p1_tail_gnt", sampledGnt, 5'b00010);
    setPort(2, HD, 32'h120); applyStimulus('0);
    checkOutput("p2_head_gnt", sampledGnt, 5'b00100);
    checkOutput("p2_head_vc", out_vc, 2'b01);
    checkOutput("no_err_yet", err, 1'b0);

    // Credit overflow on VC1: raise it to FCPD, then pulse once more.
    applyStimulus(2'b10);
    checkOutput("vc1_full_err", err, 1'b0);
    applyStimulus(2'b10);
    checkOutput("overflow_err", err, 1'b1);
    applyStimulus('0);
    checkOutput("overflow_err_sticky", err, 1'b1);

    // Drain VC1 (port 3 holds it). The fifth body flit stalls. A credit pulse
    // does not unblock it in the same cycle, but it does in the next cycle.
    for (int i = 0; i < 4; i++) begin
      setPort(3, DT, 32'h131 + i); applyStimulus('0);
      checkOutput("drain_gnt", sampledGnt, 5'b01000);
    end
    setPort(3, DT, 32'h135); applyStimulus('0);
    checkOutput("stall_gnt", sampledGnt, 5'b00000);
    setPort(3, DT, 32'h135); applyStimulus(2'b10);
    checkOutput("stall_credit_same_cycle", sampledGnt, 5'b00000);
    setPort(3, DT, 32'h135); applyStimulus('0);
    checkOutput("after_credit_gnt", sampledGnt, 5'b01000);
    checkOutput("after_credit_data", out_data, 32'h135);

    // Reset in the middle of a packet. Port 3's head then allocates VC0 from a clean state.
    rst = 1'b1;
    setPort(3, DT, 32'h136); applyStimulus('0);
    checkOutput("gnt_mid_reset", sampledGnt, 5'b00000);
    applyStimulus('0);
    rst = 1'b0;
    checkOutput("mid_reset_err", err, 1'b0);
    setPort(3, HD, 32'h300); applyStimulus('0);
    checkOutput("clean_head_gnt", sampledGnt, 5'b01000);
    checkOutput("clean_head_vc", out_vc, 2'b01);
    // A head flit from a port that already holds a VC is a protocol error.
    setPort(3, HD, 32'h301); applyStimulus('0);
    checkOutput("proto_head_gnt", sampledGnt, 5'b00000);
    checkOutput("proto_head_err", err, 1'b1);

    // Stats: after reset, send 65537 single-flit packets with credits looped back.
    rst = 1'b1;
    applyStimulus('0);
    applyStimulus('0);
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      setPort(0, HT, i);
      applyStimulus((i == 0) ? 2'b00 : 2'b01);
    end
    applyStimulus(2'b01);
    checkOutput("stats_err", err, 1'b0);
`ifdef VC_OUTPORT_STATS_EN
    checkOutput("stats_wrap", stat_flits, 16'd1);
`else
    checkOutput("stats_tied_zero", stat_flits, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
